// File: rtl/rs_gf_inv_iter_if.sv
// Handshake and result bus of the iterative GF(2^M) inverter.
// The requester drives START/DATA_IN; the inverter returns BUSY, DONE, DATA_OUT and ZERO.
interface rs_gf_inv_iter_if #(
   parameter int M = 8
) ();
   logic         START;
   logic [M-1:0] DATA_IN;
   logic         BUSY;
   logic         DONE;
   logic [M-1:0] DATA_OUT;
   logic         ZERO;

   modport master (
      output START, DATA_IN,
      input  BUSY, DONE, DATA_OUT, ZERO
   );

   modport slave (
      input  START, DATA_IN,
      output BUSY, DONE, DATA_OUT, ZERO
   );
endinterface

// File: rtl/rs_gf_inv_iter.sv
// Iterative GF(2^M) multiplicative inverter.
// Computes a^(2^M-2) as the product a^2 * a^4 * ... * a^(2^(M-1)).
// One square and one multiply are performed per cycle, for M-1 cycles.
// A zero operand flows through the same datapath; its result is 0 and ZERO is flagged.
module rs_gf_inv_iter #(
   parameter int         M    = 8,
   parameter logic [M:0] POLY = 9'h187
) (
   input logic              CLK,
   input logic              RESET,
   rs_gf_inv_iter_if.slave  bus
);

   localparam int           CW       = $clog2(M);
   localparam logic [CW-1:0] LAST_CNT = CW'(M - 2);
   localparam logic [M-1:0] ONE      = {{(M-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   // Bit-parallel GF(2^M) multiply: shift-and-add with reduction by POLY at each shift.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M-1:0] p;
      logic [M-1:0] t;
      p = '0;
      t = a;
      for (int i = 0; i < M; i++) begin
         if (b[i]) begin
            p = p ^ t;
         end else begin
            p = p;
         end
         if (t[M-1]) begin
            t = (t << 1) ^ POLY[M-1:0];
         end else begin
            t = t << 1;
         end
      end
      return p;
   endfunction

   state_t        state_r, state_s;
   logic [M-1:0]  sq_r, sq_s;
   logic [M-1:0]  acc_r, acc_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          zero_op_r, zero_op_s;
   logic [M-1:0]  data_out_r, data_out_s;
   logic          zero_r, zero_s;
   logic          done_r, done_s;
   logic [M-1:0]  sq_sqr_s;
   logic [M-1:0]  prod_s;

   assign sq_sqr_s = gf_mul(sq_r, sq_r);
   assign prod_s   = gf_mul(acc_r, sq_sqr_s);

   // State and datapath registers; reset clears every register immediately.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r    <= IDLE;
         sq_r       <= '0;
         acc_r      <= '0;
         cnt_r      <= '0;
         zero_op_r  <= 1'b0;
         data_out_r <= '0;
         zero_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         sq_r       <= sq_s;
         acc_r      <= acc_s;
         cnt_r      <= cnt_s;
         zero_op_r  <= zero_op_s;
         data_out_r <= data_out_s;
         zero_r     <= zero_s;
         done_r     <= done_s;
      end
   end

   // Next-state and next-datapath logic: load on accept, square-and-multiply while calculating.
   always_comb begin
      state_s    = state_r;
      sq_s       = sq_r;
      acc_s      = acc_r;
      cnt_s      = cnt_r;
      zero_op_s  = zero_op_r;
      data_out_s = data_out_r;
      zero_s     = zero_r;
      done_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.START) begin
               sq_s      = bus.DATA_IN;
               acc_s     = ONE;
               cnt_s     = '0;
               zero_op_s = (bus.DATA_IN == '0);
               state_s   = CALC;
            end else begin
               state_s   = IDLE;
            end
         end
         CALC: begin
            sq_s  = sq_sqr_s;
            acc_s = prod_s;
            cnt_s = cnt_r + CW'(1);
            if (cnt_r == LAST_CNT) begin
               // Final factor a^(2^(M-1)) folded in: publish the result this edge.
               data_out_s = prod_s;
               zero_s     = zero_op_r;
               done_s     = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s    = CALC;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign bus.BUSY     = (state_r == CALC);
   assign bus.DONE     = done_r;
   assign bus.DATA_OUT = data_out_r;
   assign bus.ZERO     = zero_r;

endmodule
